mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, default 32, number of 32-bit words in the attached data memory; AW, default 5, memory word-index width.
REQ-002 Ports SHALL be, in this order: clk  in  1  single clock, all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_valid  in  1  pipeline MEM-stage request present.
REQ-005 req_ready  out  1  controller accepts request this cycle.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_addr  in  32  word index (memory indexes addr[AW-1:0]).
REQ-008 req_wdata  in  32  store data.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-011 rsp_err  out  1  request address >= DEPTH; qualified by rsp_valid.
REQ-012 stall  out  1  pipeline hold: req_valid & ~req_ready, or state != IDLE.
REQ-013 mem_wr, mem_rd  out  1 each  memory write/read strobes.
REQ-014 mem_addr  out  32  memory address; mem_wdata  out  32  memory write data; mem_rdata  in  32  combinational memory read data.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-016 IDLE: req_ready=1; on req_valid, capture we/addr/wdata into request registers and go to ACCESS.
REQ-017 ACCESS: req_ready=0; if captured addr < DEPTH, drive mem_addr=captured addr, mem_wr=we, mem_rd=~we for exactly this one cycle; a load captures mem_rdata into rsp_rdata at the end of this cycle; go to RESP.
REQ-018 ACCESS with captured addr >= DEPTH: mem_wr=mem_rd=0, no memory write occurs, rsp_err set, rsp_rdata=0; go to RESP.
REQ-019 RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err stable; req_ready=0; next state IDLE.
REQ-020 Throughput SHALL be one request per 3 cycles; accept-to-rsp_valid latency exactly 2 cycles.
REQ-021 mem_wr and mem_rd SHALL never be asserted together, and both SHALL be 0 outside ACCESS.
REQ-022 mem_addr and mem_wdata SHALL be 0 outside ACCESS.
REQ-023 Store response: rsp_rdata=0, rsp_err=0 when in range.
REQ-024 req_* inputs SHALL be ignored outside IDLE; changes after acceptance do not affect the transaction.
REQ-025 Back-to-back: a request held valid through RESP is accepted in the following IDLE cycle.
REQ-026 Address compare SHALL use all 32 bits of req_addr (no wrap-around aliasing into the memory).

Reset
REQ-027 Reset asserted in any state SHALL, on the next posedge, force IDLE and clear all request registers, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_rd; in-flight transaction is dropped with no response.
REQ-028 While reset is high, req_ready=0 and no request is accepted; memory contents are not touched by this block.

Structure
REQ-029 State encoding (IDLE/ACCESS/RESP) and DEPTH/AW defaults SHALL live in the shared processor package.
REQ-030 Single module, no sub-modules; instantiated in the MEM stage between pipeline register and data memory.

Verification
REQ-031 Store addr 8 data 0x000000CC, then load addr 8 -> memory write in ACCESS cycle; load rsp_rdata=0x000000CC, rsp_valid 2 cycles after accept.
REQ-032 Load addr 0 after reset with memory preset to 100 -> rsp_rdata=100, rsp_err=0, single-cycle mem_rd.
REQ-033 Store addr 40 (>= 32) -> mem_wr never asserted, rsp_err=1, rsp_rdata=0; subsequent load addr 8 unchanged.
REQ-034 req_valid held high with 3 consecutive loads (addr 0, 8, 12) -> accepts every 3rd cycle, stall high between accepts, responses in order.
REQ-035 Reset asserted in ACCESS of a store -> no rsp_valid, all outputs 0 next cycle, state IDLE, req_ready=1 the cycle after reset deasserts.
REQ-036 Change req_addr/req_wdata during ACCESS -> transaction uses captured values only.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared processor package for the MEM-stage data memory access controller.
//   Holds the controller state encoding and the default geometry of the
//   attached data memory so the pipeline and the controller agree on them.
//   No ports; import with mem_access_ctrl_pkg::*.

package mem_access_ctrl_pkg;

    // Default data memory geometry: 32 words of 32 bits, 5-bit word index.
    localparam int MEM_DEPTH_DEFAULT = 32;
    localparam int MEM_AW_DEFAULT    = 5;

    // Controller phases: wait for a request, touch memory once, report.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sits in the MEM stage between the pipeline register and the data memory.
//   Each request takes three cycles: accept (IDLE), one memory access cycle
//   (ACCESS) and a one-cycle response pulse (RESP). Out-of-range addresses
//   never reach the memory and are reported through rsp_err.
//
//   Ports
//     clk        : single clock, posedge
//     reset      : synchronous active-high reset
//     req_valid  : request present from the pipeline
//     req_ready  : request accepted this cycle (IDLE and not in reset)
//     req_we     : 1 = store, 0 = load
//     req_addr   : 32-bit word index
//     req_wdata  : store data
//     rsp_valid  : one-cycle response pulse
//     rsp_rdata  : load data, 0 for stores and errors
//     rsp_err    : address was >= DEPTH
//     stall      : pipeline hold
//     mem_wr     : memory write strobe
//     mem_rd     : memory read strobe
//     mem_addr   : memory word address
//     mem_wdata  : memory write data
//     mem_rdata  : combinational memory read data

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEFAULT,
    parameter int AW    = MEM_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    mac_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        in_range;

    // The full 32-bit address is compared so a large index can never alias
    // onto a valid word through the truncated memory index.
    assign in_range = (addr_q < DEPTH_W);

    // Next-state logic: capture the request in IDLE, latch the load data or
    // error flag at the end of ACCESS, and return to IDLE after one RESP cycle.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                err_d   = ~in_range;
                rdata_d = (in_range && !we_q) ? mem_rdata : 32'd0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Output decode. Strobes are also gated by reset so memory is never
    // touched while reset is high, even if reset lands in the ACCESS cycle.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !reset;
        stall     = (req_valid && !req_ready) || (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state_q == ST_ACCESS && in_range) begin
            mem_wr   = we_q && !reset;
            mem_rd   = !we_q && !reset;
            mem_addr = {{(32-AW){1'b0}}, addr_q[AW-1:0]};
            if (we_q) begin
                mem_wdata = wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Drives directed and random requests into mem_access_ctrl backed by a
//   32-word memory, and compares every cycle against a transaction-level
//   reference: a request accepted in cycle c touches memory in c+1 and
//   responds in c+2, with results computed from a reference memory array.

module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem    [32];
    logic [31:0] refMem [32];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: one pending transaction at most.
    bit          pend = 0;
    int          acceptCycle = 0;
    int          cyc = 0;
    bit          tWe = 0;
    logic [31:0] tAddr = 0;
    logic [31:0] tWdata = 0;
    logic [31:0] expRdata = 0;
    bit          expErr = 0;
    bit          prevRst = 0;

    mem_access_ctrl #(.DEPTH(32), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on posedge.
    assign mem_rdata = mem[mem_addr[4:0]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[4:0]] <= mem_wdata;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got=0x%08h expected=0x%08h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the transaction
    // model, then advance the model across the posedge.
    task automatic applyStimulus(input bit rst, input bit v, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int  d;
        bit  access, resp, inRange, expReady;
        reset     = rst;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        d        = cyc - acceptCycle;
        access   = pend && (d == 1);
        resp     = pend && (d == 2);
        inRange  = (tAddr < 32);
        expReady = !pend && !rst;

        checkOutput("req_ready", {31'd0, req_ready}, {31'd0, expReady});
        checkOutput("stall", {31'd0, stall}, {31'd0, (v && !expReady) || pend});
        checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, resp});
        checkOutput("mem_wr", {31'd0, mem_wr}, {31'd0, access && inRange && tWe && !rst});
        checkOutput("mem_rd", {31'd0, mem_rd}, {31'd0, access && inRange && !tWe && !rst});
        checkOutput("mem_addr", mem_addr, (access && inRange) ? tAddr : 32'd0);
        checkOutput("mem_wdata", mem_wdata, (access && inRange && tWe) ? tWdata : 32'd0);
        if (resp) begin
            checkOutput("rsp_rdata", rsp_rdata, expRdata);
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, expErr});
        end
        if (prevRst) begin
            checkOutput("rst_rdata", rsp_rdata, 32'd0);
            checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
        end

        if (rst) begin
            pend = 0;
        end else if (access) begin
            expErr   = !inRange;
            expRdata = (inRange && !tWe) ? refMem[tAddr[4:0]] : 32'd0;
            if (inRange && tWe) refMem[tAddr[4:0]] = tWdata;
        end else if (resp) begin
            pend = 0;
        end else if (!pend && v) begin
            pend        = 1;
            acceptCycle = cyc;
            tWe         = we;
            tAddr       = addr;
            tWdata      = wdata;
        end
        prevRst = rst;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // A lone request followed by two idle cycles with junk on the request bus.
    task automatic oneRequest(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(0, 1, we, addr, wdata);
        applyStimulus(0, 0, $urandom_range(0, 1), $urandom, $urandom);
        applyStimulus(0, 0, $urandom_range(0, 1), $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 32; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        mem[0]    = 32'd100;
        refMem[0] = 32'd100;
        reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        @(posedge clk);
        @(negedge clk);
        prevRst = 1;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'd3, 32'hDEAD_BEEF);

        // Load after reset, store then load back, out-of-range store.
        oneRequest(0, 32'd0, 32'd0);
        oneRequest(1, 32'd8, 32'h0000_00CC);
        oneRequest(0, 32'd8, 32'd0);
        oneRequest(1, 32'd40, 32'h1234_5678);
        oneRequest(0, 32'd8, 32'd0);
        oneRequest(1, 32'h8000_0008, 32'h5555_AAAA);
        oneRequest(0, 32'd8, 32'd0);

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 32'd0 : (i == 1) ? 32'd8 : 32'd12;
            for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, a, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0);

        // Reset landing in the ACCESS cycle of a store.
        applyStimulus(0, 1, 1, 32'd5, 32'hCAFE_F00D);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        oneRequest(0, 32'd5, 32'd0);

        // Random traffic including occasional reset and wide addresses.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 39));
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 1), a, $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("mem[%0d]", i), mem[i], refMem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
